// File: rtl/ghost_nav_fsm.sv
// Ghost navigator: owns the ghost tile position, picks a direction once per move step
// under a SCATTER/CHASE timer with a no-reverse rule. Define GHOST_FRIGHT_EN to add FRIGHT mode.
module ghost_nav_fsm #(
  parameter int         POS_W         = 6,
  parameter int         START_X       = 13,
  parameter int         START_Y       = 11,
  parameter int         SCATTER_X     = 0,
  parameter int         SCATTER_Y     = 0,
  parameter int         MOVE_DIV      = 4,
  parameter int         SCATTER_STEPS = 7,
  parameter int         CHASE_STEPS   = 20,
  parameter int         FRIGHT_STEPS  = 6,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [POS_W-1:0] targetPosX,
  input  logic [POS_W-1:0] targetPosY,
  input  logic             canMoveU,
  input  logic             canMoveR,
  input  logic             canMoveD,
  input  logic             canMoveL,
  input  logic             frightenReq,
  output logic [POS_W-1:0] ghostPosX,
  output logic [POS_W-1:0] ghostPosY,
  output logic [1:0]       dirToMove,
  output logic [1:0]       mode,
  output logic             moveStrobe
);

  typedef enum logic [1:0] {SCATTER = 2'b00, CHASE = 2'b01, FRIGHT = 2'b10} mode_e;

  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_L = 2'd3;

  localparam int DW        = POS_W + 1;
  localparam int SC_W      = $clog2(MOVE_DIV);
  localparam int MAX_STEPS = (SCATTER_STEPS > CHASE_STEPS) ? SCATTER_STEPS : CHASE_STEPS;
  localparam int MC_W      = $clog2(MAX_STEPS + 1);

  mode_e                state, nxt_state;
  logic [SC_W-1:0]      step_cnt;
  logic [MC_W-1:0]      mode_cnt, nxt_cnt;
  logic                 step, commit, pick_ok;
  logic [POS_W-1:0]     tgt_x, tgt_y;
  logic signed [DW-1:0] dx, dy;
  logic [DW-1:0]        adx, ady;
  logic [1:0]           pref_x, pref_y, rev_dir, pick_dir;
  logic [3:0][1:0]      cand;
  logic [3:0]           legal;

`ifdef GHOST_FRIGHT_EN
  localparam int FC_W = $clog2(FRIGHT_STEPS + 1);
  logic [7:0]      lfsr;
  logic [FC_W-1:0] fright_cnt;
  logic [MC_W-1:0] saved_cnt;
  mode_e           saved_mode;
  logic            fright_first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  logic [9:0] unused_cfg;
  assign unused_cfg = {frightenReq, LFSR_SEED, 1'(FRIGHT_STEPS)};
`endif

  assign mode    = state;
  assign legal   = {canMoveL, canMoveD, canMoveR, canMoveU};
  assign rev_dir = dirToMove ^ 2'b10;
  assign step    = enable && (step_cnt == SC_W'(MOVE_DIV - 1));
  assign commit  = step && pick_ok;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tgt_x  = (state == CHASE) ? targetPosX : POS_W'(SCATTER_X);
    tgt_y  = (state == CHASE) ? targetPosY : POS_W'(SCATTER_Y);
    dx     = $signed({1'b0, tgt_x}) - $signed({1'b0, ghostPosX});
    dy     = $signed({1'b0, tgt_y}) - $signed({1'b0, ghostPosY});
    adx    = dx[DW-1] ? $unsigned(-dx) : $unsigned(dx);
    ady    = dy[DW-1] ? $unsigned(-dy) : $unsigned(dy);
    pref_x = dx[DW-1] ? DIR_L : DIR_R;
    pref_y = dy[DW-1] ? DIR_U : DIR_D;
    // Y wins ties; the opposite candidates are the preferred ones flipped.
    cand[0] = (ady >= adx) ? pref_y : pref_x;
    cand[1] = (ady >= adx) ? pref_x : pref_y;
    cand[2] = cand[1] ^ 2'b10;
    cand[3] = cand[0] ^ 2'b10;

    pick_ok  = 1'b0;
    pick_dir = dirToMove;
    for (int i = 3; i >= 0; i--) begin
      if (legal[cand[i]] && cand[i] != rev_dir) begin
        pick_ok  = 1'b1;
        pick_dir = cand[i];
      end
    end
`ifdef GHOST_FRIGHT_EN
    if (state == FRIGHT) begin
      pick_ok  = 1'b0;
      pick_dir = dirToMove;
      for (int i = 3; i >= 0; i--) begin
        if (legal[lfsr[1:0] + 2'(i)] && (lfsr[1:0] + 2'(i)) != rev_dir) begin
          pick_ok  = 1'b1;
          pick_dir = lfsr[1:0] + 2'(i);
        end
      end
    end
`endif
    if (!pick_ok && legal[rev_dir]) begin
      pick_ok  = 1'b1;
      pick_dir = rev_dir;
    end
`ifdef GHOST_FRIGHT_EN
    if (state == FRIGHT && fright_first && legal[rev_dir]) begin
      pick_ok  = 1'b1;
      pick_dir = rev_dir;
    end
`endif
  end

  // Mode timer only advances on steps that actually moved the ghost.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = mode_cnt;
    if (commit) begin
      case (state)
        SCATTER: begin
          if (mode_cnt == MC_W'(SCATTER_STEPS - 1)) begin
            nxt_state = CHASE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = mode_cnt + 1'b1;
          end
        end
        CHASE: begin
          if (mode_cnt == MC_W'(CHASE_STEPS - 1)) begin
            nxt_state = SCATTER;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = mode_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghostPosX  <= POS_W'(START_X);
      ghostPosY  <= POS_W'(START_Y);
      dirToMove  <= DIR_L;
      state      <= SCATTER;
      step_cnt   <= '0;
      mode_cnt   <= '0;
      moveStrobe <= 1'b0;
`ifdef GHOST_FRIGHT_EN
      fright_cnt   <= '0;
      saved_cnt    <= '0;
      saved_mode   <= SCATTER;
      fright_first <= 1'b0;
`endif
    end else begin
      moveStrobe <= 1'b0;
      if (enable) begin
        step_cnt <= step ? '0 : step_cnt + 1'b1;
        if (commit) begin
          dirToMove  <= pick_dir;
          moveStrobe <= 1'b1;
          case (pick_dir)
            DIR_U:   ghostPosY <= ghostPosY - 1'b1;
            DIR_R:   ghostPosX <= ghostPosX + 1'b1;
            DIR_D:   ghostPosY <= ghostPosY + 1'b1;
            default: ghostPosX <= ghostPosX - 1'b1;
          endcase
        end
`ifdef GHOST_FRIGHT_EN
        if (frightenReq) begin
          fright_cnt <= '0;
          if (state != FRIGHT) begin
            // Save the post-step mode so a same-cycle timer expiry is not lost.
            state        <= FRIGHT;
            saved_mode   <= nxt_state;
            saved_cnt    <= nxt_cnt;
            fright_first <= 1'b1;
          end else if (commit) begin
            fright_first <= 1'b0;
          end
        end else if (state == FRIGHT) begin
          if (commit) begin
            fright_first <= 1'b0;
            if (fright_cnt == FC_W'(FRIGHT_STEPS - 1)) begin
              state      <= saved_mode;
              mode_cnt   <= saved_cnt;
              fright_cnt <= '0;
            end else begin
              fright_cnt <= fright_cnt + 1'b1;
            end
          end
        end else begin
          state    <= nxt_state;
          mode_cnt <= nxt_cnt;
        end
`else
        state    <= nxt_state;
        mode_cnt <= nxt_cnt;
`endif
      end
    end
  end

endmodule
